// File: rtl/pc_gen.sv
// Program-counter generator for the rvseed fetch stage: boot delay, fetch handshake,
// trap/branch redirects, halt and misalignment pulse. Optional RVSEED_PC_RVC_EN adds 16-bit steps.
module pc_gen #(
   parameter int                PC_W      = 32,
   parameter logic [PC_W-1:0]   RESET_VEC = '0,
   parameter int                BOOT_DLY  = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            fetch_vld,
   input  logic            fetch_rdy,
   output logic [PC_W-1:0] fetch_pc,
   input  logic            br_vld,
   input  logic [PC_W-1:0] br_pc,
   input  logic            trap_vld,
   input  logic [PC_W-1:0] trap_pc,
   input  logic            halt_req,
`ifdef RVSEED_PC_RVC_EN
   input  logic            inst_len16,
`endif
   output logic            misalign_err,
   output logic            halted
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   localparam logic [3:0] BOOT_CNT   = 4'(BOOT_DLY);
   localparam state_e     RESET_ST   = (BOOT_DLY == 0) ? ST_RUN : ST_BOOT;
   localparam logic       RESET_VLD  = (BOOT_DLY == 0);

`ifdef RVSEED_PC_RVC_EN
   localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(1);
   logic [PC_W-1:0] inc;
   assign inc = inst_len16 ? PC_W'(2) : PC_W'(4);
`else
   localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(3);
   logic [PC_W-1:0] inc;
   assign inc = PC_W'(4);
`endif

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            vld_q, vld_d;
   logic            halted_q, halted_d;
   logic            mis_q, mis_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= RESET_ST;
         cnt_q    <= BOOT_CNT;
         pc_q     <= RESET_VEC;
         vld_q    <= RESET_VLD;
         halted_q <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pc_q     <= pc_d;
         vld_q    <= vld_d;
         halted_q <= halted_d;
         mis_q    <= mis_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      mis_d   = 1'b0;
      unique case (state_q)
         ST_BOOT: begin
            // Redirects and halt are deliberately ignored until the first fetch
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (trap_vld) begin
               pc_d  = trap_pc & ~ALIGN_MASK;
               mis_d = |(trap_pc & ALIGN_MASK);
            end else if (br_vld) begin
               pc_d  = br_pc & ~ALIGN_MASK;
               mis_d = |(br_pc & ALIGN_MASK);
            end else if (halt_req) begin
               state_d = ST_HALT;
            end else if (fetch_rdy) begin
               // Wraps modulo 2^PC_W by construction
               pc_d = pc_q + inc;
            end
         end
         ST_HALT: begin
            if (trap_vld) begin
               pc_d    = trap_pc & ~ALIGN_MASK;
               mis_d   = |(trap_pc & ALIGN_MASK);
               state_d = ST_RUN;
            end
         end
         default: state_d = RESET_ST;
      endcase
      vld_d    = (state_d == ST_RUN);
      halted_d = (state_d == ST_HALT);
   end

   assign fetch_vld    = vld_q;
   assign fetch_pc     = pc_q;
   assign halted       = halted_q;
   assign misalign_err = mis_q;

endmodule
